// File: rtl/zx_kbd_pkg.sv
// Shared types, matrix coordinates and composite-key tables for the
// PS/2 to ZX Spectrum keyboard matrix.
package zx_kbd_pkg;

    typedef struct packed {
        logic       valid;
        logic [2:0] row;
        logic [2:0] col;
    } kpos_t;

    localparam int NUM_ROWS = 8;
    localparam int NUM_COLS = 5;
    localparam int NUM_COMP = 8;

    localparam logic [2:0] ROW_CSV   = 3'd0;
    localparam logic [2:0] ROW_ASDFG = 3'd1;
    localparam logic [2:0] ROW_QWERT = 3'd2;
    localparam logic [2:0] ROW_1_5   = 3'd3;
    localparam logic [2:0] ROW_0_6   = 3'd4;
    localparam logic [2:0] ROW_POIUY = 3'd5;
    localparam logic [2:0] ROW_ENT_H = 3'd6;
    localparam logic [2:0] ROW_SPC_B = 3'd7;

    localparam logic [2:0] COL_0 = 3'd0;
    localparam logic [2:0] COL_1 = 3'd1;
    localparam logic [2:0] COL_2 = 3'd2;
    localparam logic [2:0] COL_3 = 3'd3;
    localparam logic [2:0] COL_4 = 3'd4;

    localparam kpos_t NO_KEY = '0;
    localparam kpos_t CS_POS = {1'b1, ROW_CSV, COL_0};
    localparam kpos_t SS_POS = {1'b1, ROW_SPC_B, COL_1};

    localparam logic [2:0] H_LEFT   = 3'd0;
    localparam logic [2:0] H_RIGHT  = 3'd1;
    localparam logic [2:0] H_UP     = 3'd2;
    localparam logic [2:0] H_DOWN   = 3'd3;
    localparam logic [2:0] H_BKSP   = 3'd4;
    localparam logic [2:0] H_ESC    = 3'd5;
    localparam logic [2:0] H_COMMA  = 3'd6;
    localparam logic [2:0] H_PERIOD = 3'd7;

    function automatic kpos_t kp(input logic [2:0] row, input logic [2:0] col);
        return {1'b1, row, col};
    endfunction

    // Non-shift half of each composite key; the shift half is applied by the top.
    function automatic kpos_t comp_key(input logic [2:0] idx);
        kpos_t k;
        case (idx)
            H_LEFT:   k = kp(ROW_1_5,   COL_4);
            H_RIGHT:  k = kp(ROW_0_6,   COL_2);
            H_UP:     k = kp(ROW_0_6,   COL_3);
            H_DOWN:   k = kp(ROW_0_6,   COL_4);
            H_BKSP:   k = kp(ROW_0_6,   COL_0);
            H_ESC:    k = kp(ROW_SPC_B, COL_0);
            H_COMMA:  k = kp(ROW_SPC_B, COL_3);
            default:  k = kp(ROW_SPC_B, COL_2);
        endcase
        return k;
    endfunction

endpackage

// File: rtl/ps2_zx_decode.sv
// Combinational scancode decoder: {extended, code} -> direct matrix position
// and/or composite-key index.
module ps2_zx_decode
    import zx_kbd_pkg::*;
(
    input  logic       ext_i,
    input  logic [7:0] code_i,
    output kpos_t      direct_o,
    output logic       comp_valid_o,
    output logic [2:0] comp_idx_o
);

    always_comb begin
        direct_o     = NO_KEY;
        comp_valid_o = 1'b0;
        comp_idx_o   = H_LEFT;
        if (ext_i) begin
            case (code_i)
                8'h14: direct_o = SS_POS;
                8'h6B: begin comp_valid_o = 1'b1; comp_idx_o = H_LEFT;  end
                8'h74: begin comp_valid_o = 1'b1; comp_idx_o = H_RIGHT; end
                8'h75: begin comp_valid_o = 1'b1; comp_idx_o = H_UP;    end
                8'h72: begin comp_valid_o = 1'b1; comp_idx_o = H_DOWN;  end
                default: ;
            endcase
        end else begin
            case (code_i)
                8'h12, 8'h59: direct_o = CS_POS;
                8'h14:        direct_o = SS_POS;
                8'h1A: direct_o = kp(ROW_CSV, COL_1);
                8'h22: direct_o = kp(ROW_CSV, COL_2);
                8'h21: direct_o = kp(ROW_CSV, COL_3);
                8'h2A: direct_o = kp(ROW_CSV, COL_4);
                8'h1C: direct_o = kp(ROW_ASDFG, COL_0);
                8'h1B: direct_o = kp(ROW_ASDFG, COL_1);
                8'h23: direct_o = kp(ROW_ASDFG, COL_2);
                8'h2B: direct_o = kp(ROW_ASDFG, COL_3);
                8'h34: direct_o = kp(ROW_ASDFG, COL_4);
                8'h15: direct_o = kp(ROW_QWERT, COL_0);
                8'h1D: direct_o = kp(ROW_QWERT, COL_1);
                8'h24: direct_o = kp(ROW_QWERT, COL_2);
                8'h2D: direct_o = kp(ROW_QWERT, COL_3);
                8'h2C: direct_o = kp(ROW_QWERT, COL_4);
                8'h16: direct_o = kp(ROW_1_5, COL_0);
                8'h1E: direct_o = kp(ROW_1_5, COL_1);
                8'h26: direct_o = kp(ROW_1_5, COL_2);
                8'h25: direct_o = kp(ROW_1_5, COL_3);
                8'h2E: direct_o = kp(ROW_1_5, COL_4);
                8'h45: direct_o = kp(ROW_0_6, COL_0);
                8'h46: direct_o = kp(ROW_0_6, COL_1);
                8'h3E: direct_o = kp(ROW_0_6, COL_2);
                8'h3D: direct_o = kp(ROW_0_6, COL_3);
                8'h36: direct_o = kp(ROW_0_6, COL_4);
                8'h4D: direct_o = kp(ROW_POIUY, COL_0);
                8'h44: direct_o = kp(ROW_POIUY, COL_1);
                8'h43: direct_o = kp(ROW_POIUY, COL_2);
                8'h3C: direct_o = kp(ROW_POIUY, COL_3);
                8'h35: direct_o = kp(ROW_POIUY, COL_4);
                8'h5A: direct_o = kp(ROW_ENT_H, COL_0);
                8'h4B: direct_o = kp(ROW_ENT_H, COL_1);
                8'h42: direct_o = kp(ROW_ENT_H, COL_2);
                8'h3B: direct_o = kp(ROW_ENT_H, COL_3);
                8'h33: direct_o = kp(ROW_ENT_H, COL_4);
                8'h29: direct_o = kp(ROW_SPC_B, COL_0);
                8'h3A: direct_o = kp(ROW_SPC_B, COL_2);
                8'h31: direct_o = kp(ROW_SPC_B, COL_3);
                8'h32: direct_o = kp(ROW_SPC_B, COL_4);
                8'h66: begin comp_valid_o = 1'b1; comp_idx_o = H_BKSP;   end
                8'h76: begin comp_valid_o = 1'b1; comp_idx_o = H_ESC;    end
                8'h41: begin comp_valid_o = 1'b1; comp_idx_o = H_COMMA;  end
                8'h49: begin comp_valid_o = 1'b1; comp_idx_o = H_PERIOD; end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/ps2_zx_keymatrix.sv
// ZX Spectrum 8x5 keyboard matrix fed by mist_io ps2_key events; answers
// ULA port-FE row reads and raises reset/NMI request pulses.
module ps2_zx_keymatrix
    import zx_kbd_pkg::*;
#(
    parameter logic [7:0] RESET_CODE = 8'h07,
    parameter logic [7:0] NMI_CODE   = 8'h78
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic [10:0] ps2_key,
    input  logic [7:0]  addr_hi,
    output logic [4:0]  keys,
    output logic        reset_req,
    output logic        nmi_req
);

    logic                                 tog_q;
    logic [NUM_ROWS-1:0][NUM_COLS-1:0]    matrix_q, matrix_d, eff;
    logic [NUM_COMP-1:0]                  held_q, held_d;
    logic [NUM_COLS-1:0]                  keys_q, keys_d, hit;
    logic                                 rst_req_q, rst_req_d;
    logic                                 nmi_req_q, nmi_req_d;

    logic       evt, pressed, ext;
    logic [7:0] code;
    kpos_t      direct, ck;
    logic       comp_valid;
    logic [2:0] comp_idx;

    assign code    = ps2_key[7:0];
    assign ext     = ps2_key[8];
    assign pressed = ps2_key[9];
    assign evt     = ps2_key[10] ^ tog_q;

    ps2_zx_decode u_decode (
        .ext_i        (ext),
        .code_i       (code),
        .direct_o     (direct),
        .comp_valid_o (comp_valid),
        .comp_idx_o   (comp_idx)
    );

    always_comb begin
        matrix_d  = matrix_q;
        held_d    = held_q;
        rst_req_d = 1'b0;
        nmi_req_d = 1'b0;
        if (evt) begin
            if (code == 8'h00) begin
                matrix_d = '0;
                held_d   = '0;
            end else begin
                if (direct.valid)
                    matrix_d[direct.row][direct.col] = pressed;
                if (comp_valid)
                    held_d[comp_idx] = pressed;
                rst_req_d = pressed && !ext && (code == RESET_CODE);
                nmi_req_d = pressed && !ext && (code == NMI_CODE);
            end
        end
    end

    // Composite keys overlay the matrix so a physical shift survives a cursor release.
    always_comb begin
        eff = matrix_q;
        ck  = NO_KEY;
        for (int i = 0; i < NUM_COMP; i++) begin
            if (held_q[i]) begin
                ck = comp_key(3'(i));
                eff[ck.row][ck.col] = 1'b1;
            end
        end
        if (|held_q[H_ESC:H_LEFT])
            eff[CS_POS.row][CS_POS.col] = 1'b1;
        if (|held_q[H_PERIOD:H_COMMA])
            eff[SS_POS.row][SS_POS.col] = 1'b1;
    end

    always_comb begin
        hit = '0;
        for (int r = 0; r < NUM_ROWS; r++) begin
            for (int c = 0; c < NUM_COLS; c++) begin
                hit[c] = hit[c] | (eff[r][c] & ~addr_hi[r]);
            end
        end
        keys_d = ~hit;
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            tog_q     <= 1'b0;
            matrix_q  <= '0;
            held_q    <= '0;
            keys_q    <= 5'h1F;
            rst_req_q <= 1'b0;
            nmi_req_q <= 1'b0;
        end else begin
            tog_q     <= ps2_key[10];
            matrix_q  <= matrix_d;
            held_q    <= held_d;
            keys_q    <= keys_d;
            rst_req_q <= rst_req_d;
            nmi_req_q <= nmi_req_d;
        end
    end

    assign keys      = keys_q;
    assign reset_req = rst_req_q;
    assign nmi_req   = nmi_req_q;

endmodule
